md_ctrl: RTL and testbench
==========================

Name: md_ctrl

Overview:
- Multiply/divide controller that sits beside the EX stage of the 5-stage MIPS pipeline.
- Accepts an HI/LO-class operation from EX, captures its operands and computes the result.
- Holds busy for a fixed multi-cycle latency, then commits the result to the HI/LO registers.
- Generates the D-stage stall for any HI/LO-class instruction that arrives while busy; an exception flush (cancel) suppresses a same-cycle start.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (minimum 1)
- DIV_CYCLES, 10, busy cycles for div/divu (minimum 1)
- CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  EX-stage HI/LO-class instruction valid this cycle
- md_op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6-7 reserved
- rs_val  in  32  forwarded RS operand (dividend / multiplicand / mthi-mtlo source)
- rt_val  in  32  forwarded RT operand
- cancel  in  1  exception flush of the EX instruction this cycle
- md_use_D  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  operation in progress (combinational, see below)
- stall  out  1  md_use_D & busy

Behaviour:
- Reset (reset low, asynchronous) forces: state IDLE, counter 0, hi 0, lo 0, captured result 0. Outputs are valid immediately.
- Qualified start: go = start & ~cancel & (state==IDLE) & md_op ≤ 5.
- busy = (start & ~cancel & md_op<4) | (state != IDLE). The start cycle itself counts as busy.
- State IDLE:
  - go with mult/multu: capture the 64-bit product into the result register; counter ← MULT_CYCLES-1; state ← MULT if the counter is nonzero, else commit directly.
  - go with div/divu: capture the quotient and remainder; counter ← DIV_CYCLES-1; state ← DIV (same zero-count rule).
  - go with mthi: hi ← rs_val at this edge, state stays IDLE. go with mtlo: lo ← rs_val likewise. Neither asserts busy.
- States MULT/DIV: counter decrements each edge. At the edge where counter==1, commit {hi,lo} ← result and return to IDLE.
- Timing: busy is high for exactly N cycles (start cycle included). hi/lo change at the Nth edge after start, and are readable by mfhi/mflo in the following cycle.
- Arithmetic:
  - mult is signed 32x32→64, with hi=upper and lo=lower; multu is unsigned.
  - div: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend. divu is unsigned.
  - Divisor 0: hi/lo keep their prior values, but the full DIV_CYCLES busy period still elapses.
  - Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Boundaries:
  - start while busy: ignored. This is a protocol violation because stall prevents it; a simulation assertion flags it.
  - cancel is honoured only in the start cycle. cancel during MULT/DIV is ignored, since the running operation belongs to an older, committed instruction.
  - Reserved md_op: ignored.
  - Reset mid-operation aborts it and clears hi/lo.

Optional Feature:
- MD_ZERO_SHORTCUT_EN defined: a mult/multu with either operand 0, or a div/divu with rt_val 0, takes no busy period. busy stays low for that start. For mult, hi/lo ← 0 at the start edge; for div, hi/lo are unchanged.
- Undefined: those operations take the full MULT_CYCLES/DIV_CYCLES.

Decomposition:
- Package md_pkg: md_op encodings, state enum {IDLE, MULT, DIV}, default cycle constants.
- One natural combinational sub-module, md_arith: given op, rs and rt, it returns the 64-bit result and a div0 flag. The md_ctrl FSM, counter and HI/LO registers instantiate it.

Test Plan:
- mult rs=0xFFFFFFFE (-2), rt=3 → busy high 5 cycles; at 5th edge hi=0xFFFFFFFF, lo=0xFFFFFFFA; multu same operands → hi=0x00000002, lo=0xFFFFFFFA.
- div rs=0xFFFFFFF9 (-7), rt=2 → busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then div rt=0 → 10 busy cycles, hi/lo unchanged.
- mult started, md_use_D high during cycles 1-5 → stall high exactly those 5 cycles and low in cycle 6; a second start asserted in cycle 3 is ignored.
- start=1 and cancel=1 with div → busy low, state IDLE, hi/lo unchanged. mtlo rs=0x1234 with cancel=1 → lo unchanged.
- mthi 0xA5A5A5A5 → hi updates next edge with busy never high; then reset asserted low mid-div → hi=lo=0 and busy=0 immediately.
- With MD_ZERO_SHORTCUT_EN, mult rt=0 → busy never high, hi=lo=0 after one edge. Without the macro → 5 busy cycles.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide controller.
//   - md_op_e    : encoding of the 3-bit md_op field (6-7 reserved)
//   - md_state_e : controller FSM states
//   - default busy-cycle counts and counter width
//   - small op-class helpers used by the controller
package md_pkg;

  typedef enum logic [2:0] {
    OpMult  = 3'd0,
    OpMultu = 3'd1,
    OpDiv   = 3'd2,
    OpDivu  = 3'd3,
    OpMthi  = 3'd4,
    OpMtlo  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMult = 2'd1,
    StDiv  = 2'd2
  } md_state_e;

  localparam int unsigned DefMultCycles = 5;
  localparam int unsigned DefDivCycles  = 10;
  localparam int unsigned DefCntW       = 4;

  // mult/multu occupy codes 0-1, div/divu codes 2-3.
  function automatic logic is_mult_op(input logic [2:0] op);
    return op[2:1] == 2'b00;
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return op[2:1] == 2'b01;
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath.
//   op_i     : md_op encoding (only mult/multu/div/divu produce a result)
//   rs_i     : multiplicand / dividend
//   rt_i     : multiplier / divisor
//   result_o : {hi, lo}; product for mult, {remainder, quotient} for div
//   div0_o   : div/divu with a zero divisor (result_o is then meaningless)
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic [63:0] result_o,
  output logic        div0_o
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        div0;
  logic        ovf;
  logic [31:0] dsor_s;
  logic [31:0] dsor_u;
  logic [31:0] quot_s;
  logic [31:0] rem_s;
  logic [31:0] quot_u;
  logic [31:0] rem_u;

  assign prod_s = $signed({{32{rs_i[31]}}, rs_i}) * $signed({{32{rt_i[31]}}, rt_i});
  assign prod_u = {32'b0, rs_i} * {32'b0, rt_i};

  assign div0 = (rt_i == 32'd0);
  // -2^31 / -1 overflows 32 bits; dividing by +1 gives the required
  // quotient 0x80000000 and remainder 0 without a separate mux.
  assign ovf  = (rs_i == 32'h8000_0000) && (rt_i == 32'hFFFF_FFFF);

  // Keep the dividers away from a zero divisor; the result is discarded then.
  assign dsor_s = (div0 || ovf) ? 32'd1 : rt_i;
  assign dsor_u = div0 ? 32'd1 : rt_i;

  // Signed / and % truncate toward zero; remainder takes the dividend's sign.
  assign quot_s = $signed(rs_i) / $signed(dsor_s);
  assign rem_s  = $signed(rs_i) % $signed(dsor_s);
  assign quot_u = rs_i / dsor_u;
  assign rem_u  = rs_i % dsor_u;

  always_comb begin
    result_o = '0;
    div0_o   = 1'b0;
    case (op_i)
      OpMult:  result_o = prod_s;
      OpMultu: result_o = prod_u;
      OpDiv: begin
        result_o = {rem_s, quot_s};
        div0_o   = div0;
      end
      OpDivu: begin
        result_o = {rem_u, quot_u};
        div0_o   = div0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide controller beside the EX stage.
// Captures an HI/LO-class op, holds busy for a fixed latency, then commits to
// HI/LO. mthi/mtlo write directly with no busy period.
//   clk, reset (async, active low)
//   start, md_op, rs_val, rt_val, cancel : EX-stage request
//   md_use_D : D-stage instruction touches HI/LO
//   hi, lo   : architectural HI/LO
//   busy     : op in flight (includes the start cycle), stall = md_use_D & busy
// Build option: define MD_ZERO_SHORTCUT_EN to skip the busy period for
// mult with a zero operand and div with a zero divisor.
module md_ctrl
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DefMultCycles,
  parameter int unsigned DIV_CYCLES  = DefDivCycles,
  parameter int unsigned CNT_W       = DefCntW
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        cancel,
  input  logic        md_use_D,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall
);

  localparam logic [CNT_W-1:0] MultCnt = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DivCnt  = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [63:0]      res_q, res_d;

  logic [63:0] arith_res;
  logic        arith_div0;
  logic        is_mult;
  logic        is_div;
  logic        go;
  logic        shortcut;

  md_arith u_arith (
    .op_i     (md_op),
    .rs_i     (rs_val),
    .rt_i     (rt_val),
    .result_o (arith_res),
    .div0_o   (arith_div0)
  );

  assign is_mult = is_mult_op(md_op);
  assign is_div  = is_div_op(md_op);
  assign go      = start && !cancel && (state_q == StIdle) && (md_op <= OpMtlo);

`ifdef MD_ZERO_SHORTCUT_EN
  assign shortcut = (is_mult && ((rs_val == 32'd0) || (rt_val == 32'd0))) ||
                    (is_div && (rt_val == 32'd0));
`else
  assign shortcut = 1'b0;
`endif

  assign busy  = (start && !cancel && (is_mult || is_div) && !shortcut) || (state_q != StIdle);
  assign stall = md_use_D && busy;
  assign hi    = hi_q;
  assign lo    = lo_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          if (md_op == OpMthi) begin
            hi_d = rs_val;
          end else if (md_op == OpMtlo) begin
            lo_d = rs_val;
          end else if (shortcut) begin
            // Zero product is known up front; a zero divisor leaves HI/LO alone.
            if (is_mult) begin
              hi_d = 32'd0;
              lo_d = 32'd0;
            end
          end else begin
            // A zero divisor recaptures the current HI/LO so the commit is a no-op.
            res_d = arith_div0 ? {hi_q, lo_q} : arith_res;
            cnt_d = is_mult ? MultCnt : DivCnt;
            if (cnt_d == '0) begin
              hi_d = res_d[63:32];
              lo_d = res_d[31:0];
            end else begin
              state_d = is_mult ? StMult : StDiv;
            end
          end
        end
      end
      StMult, StDiv: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = res_q[63:32];
          lo_d    = res_q[31:0];
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
    end
  end

  // The D-stage stall should keep a new op from reaching EX while busy.
  start_while_busy_a : assert property (@(posedge clk) disable iff (!reset)
    !(start && !cancel && (state_q != StIdle)))
    else $warning("md_ctrl: start while busy ignored");

endmodule

// File: tb/tb_md_ctrl.sv
module tb_md_ctrl;
  import md_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;
`ifdef MD_ZERO_SHORTCUT_EN
  localparam bit Sc = 1'b1;
`else
  localparam bit Sc = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        cancel;
  logic        md_use_D;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;

  md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .cancel   (cancel),
    .md_use_D (md_use_D),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .stall    (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: architectural result from plain 64-bit arithmetic.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cxl, input logic [31:0] h, input logic [31:0] l,
                       output logic [31:0] nh, output logic [31:0] nl, output int nb);
    longint          p, sa, sb, q, r;
    longint unsigned pu, ua, ub;
    logic [63:0]     v;
    nh = h;
    nl = l;
    nb = 0;
    if (cxl || op > 3'd5) return;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0, 3'd1: begin
        if (op == 3'd0) begin
          p = sa * sb;
          v = p;
        end else begin
          pu = ua * ub;
          v  = pu;
        end
        nh = v[63:32];
        nl = v[31:0];
        nb = (Sc && (a == 0 || b == 0)) ? 0 : MC;
      end
      3'd2, 3'd3: begin
        nb = (Sc && b == 0) ? 0 : DC;
        if (b != 0) begin
          if (op == 3'd2) begin
            q = sa / sb;
            r = sa % sb;
          end else begin
            q = longint'(ua / ub);
            r = longint'(ua % ub);
          end
          v  = q;
          nl = v[31:0];
          v  = r;
          nh = v[31:0];
        end
      end
      3'd4: nh = a;
      default: nl = a;
    endcase
  endtask

  // Issue one op with md_use_D held high; check busy/stall each cycle and
  // HI/LO before and after the commit edge.
  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic cxl, input logic [31:0] eh,
                        input logic [31:0] el, input int nb);
    int last;
    last = (nb > 1) ? nb : 1;
    @(posedge clk);
    #1;
    start = 1'b1; md_op = op; rs_val = a; rt_val = b; cancel = cxl; md_use_D = 1'b1;
    for (int k = 1; k <= last + 1; k++) begin
      @(negedge clk);
      chk({nm, " busy"}, 32'(busy), 32'(k <= nb));
      chk({nm, " stall"}, 32'(stall), 32'(k <= nb));
      if (k <= last) begin
        chk({nm, " hi hold"}, hi, cur_hi);
        chk({nm, " lo hold"}, lo, cur_lo);
      end else begin
        chk({nm, " hi"}, hi, eh);
        chk({nm, " lo"}, lo, el);
      end
      @(posedge clk);
      #1;
      start = 1'b0; cancel = 1'b0;
    end
    md_use_D = 1'b0;
    cur_hi = eh;
    cur_lo = el;
  endtask

  typedef struct {
    string       nm;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cxl;
    logic [31:0] eh;
    logic [31:0] el;
    int          nb;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [31:0] eh, el, a, b;
    logic [2:0]  op;
    logic        cxl;
    int          nb;

    vecs[0]  = '{"mult -2*3",     3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0,
                 32'hFFFF_FFFF, 32'hFFFF_FFFA, MC};
    vecs[1]  = '{"multu",         3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0,
                 32'h0000_0002, 32'hFFFF_FFFA, MC};
    vecs[2]  = '{"div -7/2",      3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0,
                 32'hFFFF_FFFF, 32'hFFFF_FFFD, DC};
    vecs[3]  = '{"div by 0",      3'd2, 32'd5, 32'd0, 1'b0,
                 32'hFFFF_FFFF, 32'hFFFF_FFFD, Sc ? 0 : DC};
    vecs[4]  = '{"div ovf",       3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0,
                 32'h0, 32'h8000_0000, DC};
    vecs[5]  = '{"div cancel",    3'd2, 32'd100, 32'd7, 1'b1,
                 32'h0, 32'h8000_0000, 0};
    vecs[6]  = '{"mtlo cancel",   3'd5, 32'h1234, 32'd0, 1'b1,
                 32'h0, 32'h8000_0000, 0};
    vecs[7]  = '{"mthi",          3'd4, 32'hA5A5_A5A5, 32'd0, 1'b0,
                 32'hA5A5_A5A5, 32'h8000_0000, 0};
    vecs[8]  = '{"mtlo",          3'd5, 32'h1234, 32'd0, 1'b0,
                 32'hA5A5_A5A5, 32'h0000_1234, 0};
    vecs[9]  = '{"reserved op",   3'd6, 32'hDEAD_BEEF, 32'd1, 1'b0,
                 32'hA5A5_A5A5, 32'h0000_1234, 0};
    vecs[10] = '{"divu 100/7",    3'd3, 32'd100, 32'd7, 1'b0,
                 32'h2, 32'hE, DC};
    vecs[11] = '{"div 7/-2",      3'd2, 32'd7, 32'hFFFF_FFFE, 1'b0,
                 32'h1, 32'hFFFF_FFFD, DC};
    vecs[12] = '{"mult by 0",     3'd0, 32'd5, 32'd0, 1'b0,
                 32'h0, 32'h0, Sc ? 0 : MC};
    vecs[13] = '{"multu max",     3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
                 32'hFFFF_FFFE, 32'h1, MC};

    start = 1'b0; md_op = '0; rs_val = '0; rt_val = '0; cancel = 1'b0; md_use_D = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset stall", 32'(stall), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cxl,
             vecs[i].eh, vecs[i].el, vecs[i].nb);
    end

    // mult with D-stage user: stall for 5 cycles; cancel in cycle 2 and a
    // second start in cycle 3 must not disturb the running op.
    @(posedge clk);
    #1;
    start = 1'b1; md_op = OpMult; rs_val = 32'hFFFF_FFFE; rt_val = 32'd3;
    cancel = 1'b0; md_use_D = 1'b1;
    for (int k = 1; k <= MC + 1; k++) begin
      @(negedge clk);
      chk("seq busy", 32'(busy), 32'(k <= MC));
      chk("seq stall", 32'(stall), 32'(k <= MC));
      if (k == MC + 1) begin
        chk("seq hi", hi, 32'hFFFF_FFFF);
        chk("seq lo", lo, 32'hFFFF_FFFA);
      end
      @(posedge clk);
      #1;
      cancel = (k == 1);
      start  = (k == 2);
      md_op  = (k == 2) ? 3'd2 : 3'd0;
      rt_val = (k == 2) ? 32'd1 : 32'd3;
    end
    md_use_D = 1'b0;
    @(negedge clk);
    chk("seq idle busy", 32'(busy), 32'h0);
    chk("seq idle hi", hi, 32'hFFFF_FFFF);

    // Reset in the middle of a div aborts it and clears HI/LO at once.
    @(posedge clk);
    #1;
    start = 1'b1; md_op = OpDiv; rs_val = 32'd100; rt_val = 32'd7; md_use_D = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre-reset busy", 32'(busy), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("mid reset hi", hi, 32'h0);
    chk("mid reset lo", lo, 32'h0);
    chk("mid reset busy", 32'(busy), 32'h0);
    chk("mid reset stall", 32'(stall), 32'h0);
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (DC) begin
      @(negedge clk);
      chk("post reset busy", 32'(busy), 32'h0);
    end
    chk("post reset lo", lo, 32'h0);
    md_use_D = 1'b0;
    cur_hi = '0;
    cur_lo = '0;

    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 9));
        default: b = 32'($urandom);
      endcase
      if ($urandom_range(0, 9) == 0) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      cxl = ($urandom_range(0, 7) == 0);
      model(op, a, b, cxl, cur_hi, cur_lo, eh, el, nb);
      run_op("rand", op, a, b, cxl, eh, el, nb);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
